// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;
endpackage

// File: rtl/muldiv_if.sv
// Operand/result bundle between the register file side and muldiv_unit.
// MULDIV_DIVZERO_FLAG_EN adds the DivZero status signal.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] OperandA;
    logic [WIDTH-1:0] OperandB;
    logic             HiWrite;
    logic             LoWrite;
    logic [WIDTH-1:0] WriteValue;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             Busy;
    logic             Done;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic             DivZero;

    modport master (output Start, Op, OperandA, OperandB, HiWrite, LoWrite, WriteValue,
                    input  Hi, Lo, Busy, Done, DivZero);
    modport slave  (input  Start, Op, OperandA, OperandB, HiWrite, LoWrite, WriteValue,
                    output Hi, Lo, Busy, Done, DivZero);
`else
    modport master (output Start, Op, OperandA, OperandB, HiWrite, LoWrite, WriteValue,
                    input  Hi, Lo, Busy, Done);
    modport slave  (input  Start, Op, OperandA, OperandB, HiWrite, LoWrite, WriteValue,
                    output Hi, Lo, Busy, Done);
`endif
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; WIDTH+1 cycles per op.
// MULDIV_DIVZERO_FLAG_EN adds a sticky DivZero flag raised with Done.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic     Clock,
    input logic     Reset,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_e           state;
    logic             div_q, sa, sb, busy_q, done_q;
    logic [WIDTH-1:0] mag_a, mag_b, acc_hi, acc_lo, hi_q, lo_q;
    logic [CW-1:0]    cnt;

    // Start-time decode: magnitudes and signs (signs forced to 0 for unsigned ops)
    logic             st_signed, st_div, st_na, st_nb;
    logic [WIDTH-1:0] st_ma, st_mb;
    assign st_signed = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
    assign st_div    = (bus.Op == OP_DIV)  || (bus.Op == OP_DIVU);
    assign st_na     = st_signed & bus.OperandA[WIDTH-1];
    assign st_nb     = st_signed & bus.OperandB[WIDTH-1];
    assign st_ma     = st_na ? -bus.OperandA : bus.OperandA;
    assign st_mb     = st_nb ? -bus.OperandB : bus.OperandB;

    // Shared step datapath: add for multiply, trial subtract for divide
    logic [WIDTH:0]     add_sum, shifted, diff;
    logic [2*WIDTH-1:0] prod, prod_neg;
    assign add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
    assign shifted  = {acc_hi, acc_lo[WIDTH-1]};
    assign diff     = shifted - {1'b0, mag_b};
    assign prod     = {acc_hi, acc_lo};
    assign prod_neg = -prod;

`ifdef MULDIV_DIVZERO_FLAG_EN
    logic dz_q;
    assign bus.DivZero = dz_q;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= ST_IDLE;
            div_q  <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
            dz_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        div_q  <= st_div;
                        sa     <= st_na;
                        sb     <= st_nb;
                        mag_a  <= st_ma;
                        mag_b  <= st_mb;
                        acc_hi <= '0;
                        acc_lo <= st_div ? st_ma : st_mb;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
`ifdef MULDIV_DIVZERO_FLAG_EN
                        dz_q   <= 1'b0;
`endif
                    end else begin
                        if (bus.HiWrite) hi_q <= bus.WriteValue;
                        if (bus.LoWrite) lo_q <= bus.WriteValue;
                    end
                end
                ST_RUN: begin
                    if (div_q) begin
                        // Restoring step: keep the difference only if it did not borrow
                        acc_hi <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
                    end else begin
                        acc_hi <= add_sum[WIDTH:1];
                        acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    if (div_q && mag_b == '0) begin
                        hi_q <= sa ? -mag_a : mag_a;
                        lo_q <= '1;
                    end else if (div_q) begin
                        hi_q <= sa ? -acc_hi : acc_hi;
                        lo_q <= (sa ^ sb) ? -acc_lo : acc_lo;
                    end else begin
                        {hi_q, lo_q} <= (sa ^ sb) ? prod_neg : prod;
                    end
`ifdef MULDIV_DIVZERO_FLAG_EN
                    dz_q   <= div_q && (mag_b == '0);
`endif
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.Hi   = hi_q;
    assign bus.Lo   = lo_q;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized + directed bench for muldiv_unit against a plain-arithmetic HI/LO model.
// Build with MULDIV_DIVZERO_FLAG_EN to also check the DivZero flag.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus();
    muldiv_unit #(.WIDTH(W)) dut (.Clock(clk), .Reset(rst), .bus(bus));

    int checks = 0;
    int failures = 0;
    logic [31:0] hi_m, lo_m;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT:  begin q = sa * sb; p = q; end
            OP_MULTU: p = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        h = p[63:32];
        l = p[31:0];
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, input string tag);
        logic [31:0] eh, el;
        int lat;
        bit seen;
        model(op, a, b, eh, el);
        @(negedge clk);
        bus.Op = op; bus.OperandA = a; bus.OperandB = b;
        bus.Start = 1'b1; bus.HiWrite = inject; bus.WriteValue = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.Start = 1'b0; bus.HiWrite = 1'b0;
        chk({tag, ":busy"}, 64'(bus.Busy), 64'd1);
        if (inject) chk({tag, ":start_drops_mthi"}, 64'(bus.Hi), 64'(hi_m));
`ifdef MULDIV_DIVZERO_FLAG_EN
        chk({tag, ":dz_clr"}, 64'(bus.DivZero), 64'd0);
`endif
        lat = 0;
        seen = 1'b0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            @(posedge clk); #1;
            if (bus.Done) begin
                seen = 1'b1;
                lat = c;
            end else if (c == 10 && inject) begin
                bus.Start = 1'b1; bus.HiWrite = 1'b1; bus.LoWrite = 1'b1;
                bus.Op = ~op; bus.OperandA = ~a; bus.OperandB = b + 1;
            end else if (c == 11 && inject) begin
                bus.Start = 1'b0; bus.HiWrite = 1'b0; bus.LoWrite = 1'b0;
                chk({tag, ":run_hold"}, {bus.Hi, bus.Lo}, {hi_m, lo_m});
            end
        end
        chk({tag, ":latency"}, 64'(lat), 64'd33);
        chk({tag, ":hilo"}, {bus.Hi, bus.Lo}, {eh, el});
        hi_m = eh;
        lo_m = el;
`ifdef MULDIV_DIVZERO_FLAG_EN
        chk({tag, ":divzero"}, 64'(bus.DivZero), 64'(op[1] && b == 0));
`endif
        @(posedge clk); #1;
        chk({tag, ":done_pulse"}, {62'd0, bus.Done, bus.Busy}, 64'd0);
    endtask

    task automatic mv(input bit hw, input bit lw, input logic [31:0] v, input string tag);
        @(negedge clk);
        bus.HiWrite = hw; bus.LoWrite = lw; bus.WriteValue = v;
        @(posedge clk); #1;
        bus.HiWrite = 1'b0; bus.LoWrite = 1'b0;
        if (hw) hi_m = v;
        if (lw) lo_m = v;
        chk(tag, {bus.Hi, bus.Lo}, {hi_m, lo_m});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit saw_done;
        bus.Start = 1'b0; bus.Op = 2'b00; bus.OperandA = '0; bus.OperandB = '0;
        bus.HiWrite = 1'b0; bus.LoWrite = 1'b0; bus.WriteValue = '0;
        rst = 1'b1;
        hi_m = '0;
        lo_m = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset:hilo", {bus.Hi, bus.Lo}, 64'd0);
        chk("reset:busy_done", {62'd0, bus.Busy, bus.Done}, 64'd0);
`ifdef MULDIV_DIVZERO_FLAG_EN
        chk("reset:divzero", 64'(bus.DivZero), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg");
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minmin");
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, "divu");
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        run_op(OP_DIVU, 32'd5, 32'd0, 1'b0, "divu_zero");
        run_op(OP_DIV, 32'hFFFF_FFF7, 32'd0, 1'b0, "div_zero_neg");
        run_op(OP_MULTU, 32'd3, 32'd4, 1'b0, "dz_cleared");

        mv(1'b1, 1'b0, 32'h0000_1234, "mthi");
        mv(1'b0, 1'b1, 32'h0000_5678, "mtlo");
        mv(1'b1, 1'b1, 32'h0000_ABCD, "mthi_mtlo");
        run_op(OP_MULTU, 32'h1234, 32'h10, 1'b1, "busy_ignore");

        // Abort a DIV mid-run with Reset
        mv(1'b1, 1'b1, 32'h5555_AAAA, "pre_abort");
        @(negedge clk);
        bus.Op = OP_DIV; bus.OperandA = 32'd1000; bus.OperandB = 32'd3; bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        hi_m = '0;
        lo_m = '0;
        chk("abort:hilo", {bus.Hi, bus.Lo}, 64'd0);
        chk("abort:busy", 64'(bus.Busy), 64'd0);
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.Done || bus.Busy) saw_done = 1'b1;
        end
        chk("abort:no_done", 64'(saw_done), 64'd0);
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, "after_abort");

        for (int i = 0; i < 30; i++) begin
            logic [1:0] op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            run_op(op, a, b, 1'b0, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
